dac_scheduler: RTL

DAC_SCHEDULER -- requirements
Module: dac_scheduler

---
 rtl/dac_sched_pkg.sv | 25 ++
 rtl/dac_rr_pick.sv | 28 ++
 rtl/dac_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC frame scheduler: FSM encoding, frame
// layout constants and the frame packing helper.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    localparam int MAX_CH  = 4;
    localparam int CH_W    = 2;
    localparam int CODE_W  = 16;
    localparam int FRAME_W = 32;

    localparam logic [3:0] FRAME_CMD = 4'h3;

    // Frame word: {pad, command, pad, channel, code, pad}
    function automatic logic [FRAME_W-1:0] make_frame(input logic [CH_W-1:0]   ch,
                                                      input logic [CODE_W-1:0] code);
        return {4'h0, FRAME_CMD, 2'b00, ch, code, 4'h0};
    endfunction

endpackage

// File: rtl/dac_rr_pick.sv
// Round-robin picker: returns the first set dirty bit strictly after the
// last served channel, wrapping around and finally considering that channel.
module dac_rr_pick
    import dac_sched_pkg::*;
(
    input  logic [MAX_CH-1:0] dirty,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   next_ch,
    output logic              valid
);

    logic [CH_W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest dirty channel wins
    always_comb begin
        next_ch = last;
        valid   = 1'b0;
        idx     = last;
        for (int i = MAX_CH; i >= 1; i--) begin
            idx = last + CH_W'(i);
            if (dirty[idx]) begin
                next_ch = idx;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_scheduler.sv
// DAC scheduler: holds per-channel shadow codes with dirty bits and streams
// one serializer frame per dirty channel, round-robin, with ack timeout
// recovery. Optional macro DAC_SCHED_PERIODIC_REFRESH_EN re-marks every
// channel dirty each REFRESH_PERIOD cycles.
module dac_scheduler
    import dac_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int ACK_TIMEOUT    = 8,
    parameter int REFRESH_PERIOD = 50_000_000
) (
    input  logic                CLK_50M,
    input  logic                RST,
    input  logic                CH_WE,
    input  logic [CH_W-1:0]     CH_SEL,
    input  logic [CODE_W-1:0]   CH_CODE,
    input  logic                UPDATE_ALL,
    output logic                DAC_WE,
    output logic [FRAME_W-1:0]  DAC_DATA,
    input  logic                DAC_BUSY,
    output logic                SCHED_BUSY,
    output logic                FRAME_DONE,
    output logic                ACK_ERR,
    output logic [CH_W-1:0]     CUR_CH
);

    localparam logic [MAX_CH-1:0] CH_MASK  = MAX_CH'((1 << NUM_CH) - 1);
    localparam logic [15:0]       ACK_LAST = 16'(ACK_TIMEOUT - 1);

    sched_state_t      state, state_next;
    logic [CODE_W-1:0] shadow [MAX_CH];
    logic [MAX_CH-1:0] dirty, dirty_next;
    logic [15:0]       ack_cnt;
    logic              frame_live;
    logic              write_hit;
    logic              refresh_tick;
    logic              pick_go, ack_ok, ack_timeout, done_go, fault;
    logic [CH_W-1:0]   pick_ch;
    logic              pick_valid;

    assign write_hit  = CH_WE && (int'(CH_SEL) < NUM_CH);
    assign SCHED_BUSY = (|dirty) | (state != IDLE);

    dac_rr_pick u_pick (
        .dirty   (dirty),
        .last    (CUR_CH),
        .next_ch (pick_ch),
        .valid   (pick_valid)
    );

`ifdef DAC_SCHED_PERIODIC_REFRESH_EN
    logic [31:0] refresh_cnt;

    // Free-running refresh interval counter
    always_ff @(posedge CLK_50M) begin
        if (RST || refresh_cnt == 32'(REFRESH_PERIOD - 1)) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end

    assign refresh_tick = (refresh_cnt == 32'(REFRESH_PERIOD - 1));
`else
    // Refresh compiled out: only host writes and UPDATE_ALL create work
    assign refresh_tick = 1'b0 && (REFRESH_PERIOD > 0);
`endif

    // State register; reset parks in WAIT_DONE so a pre-reset frame drains
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state <= WAIT_DONE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and one-cycle control strobes
    always_comb begin
        state_next  = state;
        pick_go     = 1'b0;
        ack_ok      = 1'b0;
        ack_timeout = 1'b0;
        done_go     = 1'b0;
        fault       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid && DAC_BUSY) begin
                    pick_go    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!DAC_BUSY) begin
                    ack_ok     = 1'b1;
                    state_next = WAIT_DONE;
                end else if (ack_cnt == ACK_LAST) begin
                    ack_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (DAC_BUSY) begin
                    done_go    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                fault      = 1'b1;
                state_next = WAIT_DONE;
            end
        endcase
    end

    // Dirty update; later terms win so a coincident write keeps its bit set
    always_comb begin
        dirty_next = dirty;
        if (pick_go) begin
            dirty_next[pick_ch] = 1'b0;
        end
        if (ack_timeout) begin
            dirty_next[CUR_CH] = 1'b1;
        end
        if (UPDATE_ALL || refresh_tick) begin
            dirty_next = dirty_next | CH_MASK;
        end
        if (write_hit) begin
            dirty_next[CH_SEL] = 1'b1;
        end
    end

    // Shadow codes, frame register, status flags and ack timer
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            for (int i = 0; i < MAX_CH; i++) begin
                shadow[i] <= '0;
            end
            dirty      <= '0;
            DAC_WE     <= 1'b0;
            DAC_DATA   <= '0;
            FRAME_DONE <= 1'b0;
            ACK_ERR    <= 1'b0;
            CUR_CH     <= CH_W'(NUM_CH - 1);
            ack_cnt    <= '0;
            frame_live <= 1'b0;
        end else begin
            dirty      <= dirty_next;
            DAC_WE     <= pick_go;
            FRAME_DONE <= done_go && frame_live;
            ack_cnt    <= (state == WAIT_ACK) ? ack_cnt + 16'd1 : 16'd0;
            if (write_hit) begin
                shadow[CH_SEL] <= CH_CODE;
            end
            if (pick_go) begin
                DAC_DATA <= make_frame(pick_ch, shadow[pick_ch]);
                CUR_CH   <= pick_ch;
            end
            if (ack_timeout) begin
                ACK_ERR <= 1'b1;
            end
            if (ack_ok) begin
                frame_live <= 1'b1;
            end else if (done_go || fault) begin
                frame_live <= 1'b0;
            end
        end
    end

endmodule
